vga_layer_renderer: RTL
=======================

// Module: vga_layer_renderer
// PURPOSE
//  Parametrised pixel-colour generator for the VGA path: composites a framed field plus
//  NUM_OBJ enable-gated rectangular sprites (ball, paddles, score blocks, ...) by fixed
//  priority into an RGB 3/3/2 value. The pixel path is a 2-stage pipeline.
//  Sprite geometry is double-buffered per frame so there is no tearing.
//  Optional per-sprite blinking is supported.
//  Per-frame collision flags between sprite 0 and every other sprite feed the game FSM.
//  Sits between the VGA sync counter and the DAC pins.
// PARAMETERS
//  NUM_OBJ      4     number of sprites, 1..8; index 0 = highest priority
//  FIELD_X_BEG  10    first column inside the field
//  FIELD_X_END  629   last column inside the field
//  FIELD_Y_BEG  10    first row inside the field
//  FIELD_Y_END  469   last row inside the field
//  FRAME_COLOR  8'h11 {r,g,b} colour outside the field
//  BG_COLOR     8'h00 {r,g,b} colour inside the field where no sprite is drawn
//  BLINK_LOG2   5     blink half-period is 2**(BLINK_LOG2-1) frames
// PORTS
//  clk         in   1           25 MHz pixel clock
//  reset       in   1           asynchronous, active-low
//  CounterX    in   10          current column
//  CounterY    in   10          current row
//  video_on    in   1           current pixel is in the visible area
//  frame_start in   1           1-cycle pulse at the first pixel of each frame
//  obj_x       in   10*NUM_OBJ  sprite centre column, sprite i at [10i+9:10i]
//  obj_y       in   10*NUM_OBJ  sprite centre row
//  obj_hw      in   10*NUM_OBJ  sprite half-width
//  obj_hh      in   10*NUM_OBJ  sprite half-height
//  obj_color   in   8*NUM_OBJ   {r[2:0],g[2:0],b[1:0]} per sprite
//  obj_en      in   NUM_OBJ     sprite enable
//  obj_blink   in   NUM_OBJ     sprite blinks when 1
//  r           out  3           red
//  g           out  3           green
//  b           out  2           blue
//  video_on_o  out  1           video_on delayed 2 cycles, aligned with r/g/b
//  collide     out  NUM_OBJ     bit i: sprite 0 overlapped sprite i in the previous frame (bit 0 is always 0)
// BEHAVIOUR
//  Reset (asynchronous assert, synchronous release):
//   - r, g, b, video_on_o, collide, all pipeline and shadow registers and frame_cnt go to 0.
//   - After reset, until the first frame_start, all shadow obj_en are 0, so only the field is drawn.
//   - Reset in the middle of a frame discards that frame's collision data.
//  Shadow latch:
//   - On frame_start, all obj_* inputs are copied into the shadow registers.
//   - Within a frame, compares use only the shadow copies.
//   - The pixel that carries frame_start already uses the newly latched values.
//  frame_cnt: BLINK_LOG2-bit counter, +1 on every frame_start, wraps.
//   Sprite i is visible when shadow_en[i] && !(shadow_blink[i] && frame_cnt[BLINK_LOG2-1]).
//  Stage 1 (registered):
//   - Compute the in-field flag, and hit[i] for each visible sprite.
//   - Hit test, done in 11-bit unsigned arithmetic with no subtraction, so there is
//     no wrap when hw > x:  CounterX + hw >= x && CounterX <= x + hw, and the same for Y.
//   - Boundaries are inclusive: a sprite spans 2*hw+1 by 2*hh+1 pixels.
//   - Also delay video_on by one stage.
//  Stage 2 (registered):
//   - If !video_on_d1, output 0.
//   - Else, if any hit, output the colour of the lowest-index hit sprite
//     (sprites are drawn over the frame as well).
//   - Else, if in field, output BG_COLOR; else output FRAME_COLOR.
//   - Latency: inputs at cycle t appear on r/g/b/video_on_o at t+2.
//  Collision:
//   - Sticky bit acc[i] |= hit[0] && hit[i] && video_on_d1, evaluated in stage 1.
//   - On frame_start: collide <= acc, and acc is cleared in the same cycle.
//   - If frame_start and a new hit occur in the same cycle, the hit goes into the new frame's acc.
//  Simultaneous events:
//   - frame_start during reset has no effect.
//   - Inputs that change mid-frame are ignored until the next frame_start.
// TESTING
//  1. Reset low mid-frame -> r,g,b,video_on_o,collide are 0 immediately; after release with
//     no frame_start, pixel (5,5) gives 8'h11 and (100,100) gives 8'h00, each 2 cycles later.
//  2. Sprite 1 at (320,240), hw=hh=4, colour 8'hE0, enabled, then frame_start -> pixels
//     x=316..324 on y=240 show E0; x=315 and x=325 show BG; latency is exactly 2 cycles.
//  3. Sprite 0 (colour FF) and sprite 1 (colour E0) overlap at (320,240) -> that pixel shows FF.
//     After the next frame_start, collide=4'b0010.
//  4. Sprite with x=2, hw=5 -> columns 0..7 are drawn; there is no wrap-around artefact at column ~1020.
//  5. obj_x changed mid-frame -> the drawn position is unchanged until the next frame_start.
//  6. obj_blink=1 with BLINK_LOG2=2 -> the sprite is visible for frames 0-1, hidden for 2-3,
//     visible for 4-5. collide is not set while the sprite is hidden.

Source files
------------

// File: rtl/vga_layer_renderer.sv
// Pixel colour generator: framed field plus NUM_OBJ priority-ordered rectangular sprites,
// with per-frame double-buffered geometry, optional blinking and sprite-0 collision flags.
module vga_layer_renderer #(
  parameter int          NUM_OBJ     = 4,
  parameter int          FIELD_X_BEG = 10,
  parameter int          FIELD_X_END = 629,
  parameter int          FIELD_Y_BEG = 10,
  parameter int          FIELD_Y_END = 469,
  parameter logic [7:0]  FRAME_COLOR = 8'h11,
  parameter logic [7:0]  BG_COLOR    = 8'h00,
  parameter int          BLINK_LOG2  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [9:0]              CounterX,
  input  logic [9:0]              CounterY,
  input  logic                    video_on,
  input  logic                    frame_start,
  input  logic [10*NUM_OBJ-1:0]   obj_x,
  input  logic [10*NUM_OBJ-1:0]   obj_y,
  input  logic [10*NUM_OBJ-1:0]   obj_hw,
  input  logic [10*NUM_OBJ-1:0]   obj_hh,
  input  logic [8*NUM_OBJ-1:0]    obj_color,
  input  logic [NUM_OBJ-1:0]      obj_en,
  input  logic [NUM_OBJ-1:0]      obj_blink,
  output logic [2:0]              r,
  output logic [2:0]              g,
  output logic [1:0]              b,
  output logic                    video_on_o,
  output logic [NUM_OBJ-1:0]      collide
);

  localparam logic [9:0] FXB = 10'(FIELD_X_BEG);
  localparam logic [9:0] FXE = 10'(FIELD_X_END);
  localparam logic [9:0] FYB = 10'(FIELD_Y_BEG);
  localparam logic [9:0] FYE = 10'(FIELD_Y_END);

  logic [10*NUM_OBJ-1:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic [10*NUM_OBJ-1:0] sh_hw_q, sh_hw_d, sh_hh_q, sh_hh_d;
  logic [8*NUM_OBJ-1:0]  sh_color_q, sh_color_d;
  logic [NUM_OBJ-1:0]    sh_en_q, sh_en_d, sh_blink_q, sh_blink_d;
  logic [BLINK_LOG2-1:0] frame_cnt_q, frame_cnt_d;
  logic                  any_hit_q, any_hit_d, in_field_q, in_field_d, vid1_q, vid1_d;
  logic [7:0]            hit_col_q, hit_col_d, rgb_q, rgb_d;
  logic                  vid2_q, vid2_d;
  logic [NUM_OBJ-1:0]    acc_q, acc_d, collide_q, collide_d;

  logic [NUM_OBJ-1:0]    hit, new_col;
  logic [10:0]           cx, cy, ox, oy, hw, hh;

  always_comb begin
    // The _d shadow values double as the "effective" geometry, so the frame_start
    // pixel already sees the freshly latched sprites and frame count.
    sh_x_d      = frame_start ? obj_x     : sh_x_q;
    sh_y_d      = frame_start ? obj_y     : sh_y_q;
    sh_hw_d     = frame_start ? obj_hw    : sh_hw_q;
    sh_hh_d     = frame_start ? obj_hh    : sh_hh_q;
    sh_color_d  = frame_start ? obj_color : sh_color_q;
    sh_en_d     = frame_start ? obj_en    : sh_en_q;
    sh_blink_d  = frame_start ? obj_blink : sh_blink_q;
    frame_cnt_d = frame_start ? frame_cnt_q + BLINK_LOG2'(1) : frame_cnt_q;

    cx = {1'b0, CounterX};
    cy = {1'b0, CounterY};
    ox = '0;
    oy = '0;
    hw = '0;
    hh = '0;
    hit = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      ox = {1'b0, sh_x_d[10*i +: 10]};
      oy = {1'b0, sh_y_d[10*i +: 10]};
      hw = {1'b0, sh_hw_d[10*i +: 10]};
      hh = {1'b0, sh_hh_d[10*i +: 10]};
      hit[i] = sh_en_d[i] && !(sh_blink_d[i] && frame_cnt_d[BLINK_LOG2-1]) &&
               (cx + hw >= ox) && (cx <= ox + hw) &&
               (cy + hh >= oy) && (cy <= oy + hh);
    end

    // Colour is selected in stage 1 so a frame_start between stages cannot swap palettes.
    any_hit_d = 1'b0;
    hit_col_d = '0;
    for (int unsigned i = 0; i < NUM_OBJ; i++) begin
      if (hit[i] && !any_hit_d) begin
        any_hit_d = 1'b1;
        hit_col_d = sh_color_d[8*i +: 8];
      end
    end

    in_field_d = (CounterX >= FXB) && (CounterX <= FXE) &&
                 (CounterY >= FYB) && (CounterY <= FYE);
    vid1_d     = video_on;

    new_col = '0;
    for (int unsigned i = 1; i < NUM_OBJ; i++) begin
      new_col[i] = hit[0] && hit[i] && video_on;
    end
    acc_d     = frame_start ? new_col : (acc_q | new_col);
    collide_d = frame_start ? acc_q : collide_q;

    if (!vid1_q)         rgb_d = '0;
    else if (any_hit_q)  rgb_d = hit_col_q;
    else if (in_field_q) rgb_d = BG_COLOR;
    else                 rgb_d = FRAME_COLOR;
    vid2_d = vid1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_x_q      <= '0;
      sh_y_q      <= '0;
      sh_hw_q     <= '0;
      sh_hh_q     <= '0;
      sh_color_q  <= '0;
      sh_en_q     <= '0;
      sh_blink_q  <= '0;
      frame_cnt_q <= '0;
      any_hit_q   <= 1'b0;
      in_field_q  <= 1'b0;
      vid1_q      <= 1'b0;
      hit_col_q   <= '0;
      rgb_q       <= '0;
      vid2_q      <= 1'b0;
      acc_q       <= '0;
      collide_q   <= '0;
    end else begin
      sh_x_q      <= sh_x_d;
      sh_y_q      <= sh_y_d;
      sh_hw_q     <= sh_hw_d;
      sh_hh_q     <= sh_hh_d;
      sh_color_q  <= sh_color_d;
      sh_en_q     <= sh_en_d;
      sh_blink_q  <= sh_blink_d;
      frame_cnt_q <= frame_cnt_d;
      any_hit_q   <= any_hit_d;
      in_field_q  <= in_field_d;
      vid1_q      <= vid1_d;
      hit_col_q   <= hit_col_d;
      rgb_q       <= rgb_d;
      vid2_q      <= vid2_d;
      acc_q       <= acc_d;
      collide_q   <= collide_d;
    end
  end

  assign r          = rgb_q[7:5];
  assign g          = rgb_q[4:2];
  assign b          = rgb_q[1:0];
  assign video_on_o = vid2_q;
  assign collide    = collide_q;

endmodule
